piso_buf_256b: RTL and testbench

- 256-byte word buffer, 64 x 32-bit: parallel in, serial out.
- Host writes 32-bit words over `pin`; on a read request the oldest word is shifted out on `sout`, LSB first, one bit per cycle.
- Uses the same `val_op`/`op`/`op_ack`/`op_commit` transaction handshake as the scan-chain SIPO capture buffer, in the opposite direction.
- Feeds serial scan-in from host-supplied parallel data.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_word_fifo.sv | 59 +++++
 rtl/piso_buf_256b.sv | 130 +++++++++++++
 tb/tb_piso_buf_256b.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared encodings and defaults for the parallel-in serial-out word buffer
package piso_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/piso_word_fifo.sv
// rtl/piso_word_fifo.sv - DEPTH x WIDTH word store with wrapping pointers and occupancy count
module piso_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Strobes are guarded here as well, so a stray push when full or pop when empty is harmless.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH = 2**AW; count tracks net pushes minus pops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/piso_buf_256b.sv
// rtl/piso_buf_256b.sv - 64 x 32-bit word buffer: parallel write, LSB-first serial read
module piso_buf_256b
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             val_op,
  input  logic             op,
  input  logic [WIDTH-1:0] pin,
  output logic             op_ack,
  output logic             op_commit,
  output logic             op_err,
  output logic             sout,
  output logic             sout_val,
  output logic [AW:0]      count
);

  localparam int BW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic             op_q;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt;
  logic             push;
  logic             pop;
  logic             ack_err;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] rd_data;

  piso_word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_data(pin),
    .rd_data(rd_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // State register; reset aborts any transaction in flight without a commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the one-cycle FIFO strobes issued from ACK.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    pop        = 1'b0;
    ack_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (val_op) begin
          next_state = ACK;
        end
      end
      ACK: begin
        next_state = COMMIT;
        if (op_q == OP_WR) begin
          if (full) ack_err = 1'b1;
          else      push    = 1'b1;
        end else begin
          if (empty) begin
            ack_err = 1'b1;
          end else begin
            pop        = 1'b1;
            next_state = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (bit_cnt == BW'(WIDTH - 1)) begin
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q      <= OP_WR;
      shift_q   <= '0;
      bit_cnt   <= '0;
      op_ack    <= 1'b0;
      op_commit <= 1'b0;
      op_err    <= 1'b0;
      sout      <= 1'b0;
      sout_val  <= 1'b0;
    end else begin
      if (state == IDLE && val_op) begin
        op_q <= op;
      end
      if (pop) begin
        shift_q <= rd_data >> 1;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      op_ack    <= (next_state == ACK);
      op_commit <= (next_state == COMMIT);
      op_err    <= ack_err;
      sout_val  <= (next_state == SHIFT);
      sout      <= pop ? rd_data[0]
                 : ((state == SHIFT && next_state == SHIFT) ? shift_q[0] : 1'b0);
    end
  end

endmodule

// File: tb/tb_piso_buf_256b.sv
// tb/tb_piso_buf_256b.sv - scoreboard bench for the parallel-in serial-out word buffer
module tb_piso_buf_256b;
  import piso_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             val_op = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] pin = '0;
  logic             op_ack;
  logic             op_commit;
  logic             op_err;
  logic             sout;
  logic             sout_val;
  logic [AW:0]      count;

  piso_buf_256b #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .val_op   (val_op),
    .op       (op),
    .pin      (pin),
    .op_ack   (op_ack),
    .op_commit(op_commit),
    .op_err   (op_err),
    .sout     (sout),
    .sout_val (sout_val),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reassemble serial bits and compare each commit with the oldest expectation.
  int          nbits = 0;
  logic [31:0] acc = '0;
  int          ack_cyc = 0;
  exp_t        cur;
  always @(negedge clk) begin
    if (!reset) begin
      nbits = 0;
      acc   = '0;
    end else begin
      if (op_ack) ack_cyc = cyc;
      if (sout_val) begin
        if (nbits < 32) acc[nbits] = sout;
        nbits++;
      end
      if (op_commit) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("op_err", op_err, cur.err);
          chk("sout_bits", nbits, (cur.is_rd && !cur.err) ? 32 : 0);
          if (cur.is_rd && !cur.err) chk("read_word", acc, cur.word);
          chk("commit_latency", cyc - ack_cyc, (cur.is_rd && !cur.err) ? 33 : 1);
        end
        nbits = 0;
        acc   = '0;
      end
    end
  end

  // Reference model: a plain word queue bounded at DEPTH.
  task automatic expect_op(input logic o, input logic [31:0] d);
    exp_t e;
    e.is_rd = (o == OP_RD);
    e.err   = 1'b0;
    e.word  = d;
    if (o == OP_WR) begin
      if (model.size() == DEPTH) e.err = 1'b1;
      else model.push_back(d);
    end else begin
      if (model.size() == 0) e.err = 1'b1;
      else e.word = model.pop_front();
    end
    sb.push_back(e);
  endtask

  task automatic wait_pulse(input bit want_commit, input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(want_commit ? op_commit : op_ack) && t < 100);
    if (!(want_commit ? op_commit : op_ack)) chk(name, 0, 1);
  endtask

  task automatic do_op(input logic o, input logic [31:0] d);
    expect_op(o, d);
    @(negedge clk);
    val_op = 1'b1;
    op     = o;
    pin    = d;
    wait_pulse(1'b0, "ack_timeout");
    val_op = 1'b0;
    wait_pulse(1'b1, "commit_timeout");
    @(negedge clk);
    chk("count", count, model.size());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] tv [4];
  int          seen;
  int          c1;
  int          a2;

  initial begin
    tv[0] = 32'h07020106;
    tv[1] = 32'h37323136;
    tv[2] = 32'hdeadbeef;
    tv[3] = 32'h00001c30;

    repeat (3) @(negedge clk);
    chk("rst_op_ack", op_ack, 0);
    chk("rst_op_commit", op_commit, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_sout", sout, 0);
    chk("rst_sout_val", sout_val, 0);
    chk("rst_count", count, 0);
    reset = 1'b1;

    // Directed words in, then out in write order.
    for (int i = 0; i < 4; i++) do_op(OP_WR, tv[i]);
    for (int i = 0; i < 4; i++) do_op(OP_RD, $urandom);

    // Empty read errors without serial output.
    do_op(OP_RD, $urandom);

    // Fill, overflow, drain across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) do_op(OP_WR, 32'(i));
    do_op(OP_WR, 32'hffffffff);
    for (int i = 0; i < DEPTH; i++) do_op(OP_RD, $urandom);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      do_op(($urandom_range(0, 99) < 55) ? OP_WR : OP_RD, $urandom);
    end
    while (model.size() != 0) do_op(OP_RD, $urandom);

    // Reset in the middle of a read: bit 10 is on the wire when reset drops.
    do_op(OP_WR, 32'hdeadbeef);
    @(negedge clk);
    val_op = 1'b1;
    op     = OP_RD;
    wait_pulse(1'b0, "abort_ack_timeout");
    val_op = 1'b0;
    seen = 0;
    for (int t = 0; t < 60 && seen < 11; t++) begin
      @(negedge clk);
      if (sout_val) seen++;
    end
    chk("abort_reached_bit10", seen, 11);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_sout_val", sout_val, 0);
    chk("abort_count", count, 0);
    chk("abort_op_commit", op_commit, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_commit", op_commit, 0);
    model.delete();
    sb.delete();
    reset = 1'b1;
    do_op(OP_RD, $urandom);

    // Back-to-back: val_op held high from a write straight into a read.
    expect_op(OP_WR, 32'ha5c3_0f96);
    expect_op(OP_RD, 32'h0);
    @(negedge clk);
    val_op = 1'b1;
    op     = OP_WR;
    pin    = 32'ha5c3_0f96;
    wait_pulse(1'b1, "b2b_commit1_timeout");
    c1 = cyc;
    op = OP_RD;
    wait_pulse(1'b0, "b2b_ack2_timeout");
    a2 = cyc;
    val_op = 1'b0;
    chk("b2b_gap", a2 - c1, 2);
    wait_pulse(1'b1, "b2b_commit2_timeout");
    @(negedge clk);
    chk("b2b_count", count, model.size());

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
